// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit for the yIF/yID/yEX/yDM/yWB RV32 datapath.
// Each instruction is latched in FETCH and then walks a per-class state path.
// All strobes are registered, computed for the state being entered. The one
// exception is the beq PC select, which follows the live ALU zero flag.
// A retired-instruction counter and a sticky illegal-opcode halt are included.
module multicycle_ctrl #(
    parameter int CNT_W           = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ins,
    input  logic             zero,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic [2:0]       op,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Mem2Reg,
    output logic             Link,
    output logic             PCWrite,
    output logic [1:0]       PCSel,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OPC_R     = 7'h33;
    localparam logic [6:0] OPC_I     = 7'h13;
    localparam logic [6:0] OPC_LOAD  = 7'h03;
    localparam logic [6:0] OPC_STORE = 7'h23;
    localparam logic [6:0] OPC_BEQ   = 7'h63;
    localparam logic [6:0] OPC_JAL   = 7'h6F;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // br marks beq EXEC so PCSel[0] can follow the zero flag combinationally.
    typedef struct packed {
        logic       irwrite;
        logic       regwrite;
        logic       alusrc;
        logic [2:0] op;
        logic       memread;
        logic       memwrite;
        logic       mem2reg;
        logic       link;
        logic       pcwrite;
        logic [1:0] pcsel;
        logic       br;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{op: ALU_ADD, default: '0};

    state_t     st_q;
    ctrl_t      ctl_q;
    logic [6:0] opc_q;
    logic [2:0] f3_q;
    logic       f7_q;
    logic       halted_q;
    logic [CNT_W-1:0] retired_q;

    // Only opcode, funct3 and funct7[5] steer the control path.
    logic unused_ins;
    assign unused_ins = ^{ins[31], ins[29:15], ins[11:7]};

    function automatic logic is_legal(input logic [6:0] opc);
        return (opc == OPC_R) || (opc == OPC_I) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE) || (opc == OPC_BEQ) || (opc == OPC_JAL);
    endfunction

    // ALU operation for R/I arithmetic; everything else adds.
    function automatic logic [2:0] alu_op(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic f7);
        logic [2:0] a;
        a = ALU_ADD;
        if (opc == OPC_R || opc == OPC_I) begin
            case (f3)
                3'b000:  a = (opc == OPC_R && f7) ? ALU_SUB : ALU_ADD;
                3'b111:  a = ALU_AND;
                3'b110:  a = ALU_OR;
                3'b010:  a = ALU_SLT;
                default: a = ALU_ADD;
            endcase
        end
        return a;
    endfunction

    // Control strobes to present while sitting in state s with the given IR fields.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [6:0] opc,
                                       input logic [2:0] f3, input logic f7);
        ctrl_t c;
        // NOTE: start from the idle pattern so every field has a value on every path (no latches).
        c = CTRL_IDLE;
        case (s)
            S_FETCH:  c.irwrite = 1'b1;
            S_DECODE: c.pcwrite = !is_legal(opc) && !HALT_ON_ILLEGAL;
            S_EXEC: begin
                case (opc)
                    OPC_R:     c.op = alu_op(opc, f3, f7);
                    OPC_I: begin
                        c.alusrc = 1'b1;
                        c.op     = alu_op(opc, f3, f7);
                    end
                    OPC_LOAD, OPC_STORE: c.alusrc = 1'b1;
                    OPC_BEQ: begin
                        c.op      = ALU_SUB;
                        c.pcwrite = 1'b1;
                        c.br      = 1'b1;
                    end
                    OPC_JAL: begin
                        c.regwrite = 1'b1;
                        c.link     = 1'b1;
                        c.pcwrite  = 1'b1;
                        c.pcsel    = 2'd2;
                    end
                    default: c = CTRL_IDLE;
                endcase
            end
            S_MEM: begin
                if (opc == OPC_LOAD) begin
                    c.memread = 1'b1;
                end else begin
                    c.memwrite = 1'b1;
                    c.alusrc   = 1'b1;
                    c.pcwrite  = 1'b1;
                end
            end
            S_WB: begin
                c.regwrite = 1'b1;
                c.pcwrite  = 1'b1;
                c.mem2reg  = (opc == OPC_LOAD);
                c.alusrc   = (opc != OPC_R);
                c.op       = alu_op(opc, f3, f7);
            end
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

    // Sequencer: state, latched IR fields, registered strobes, halt flag and retire count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= S_START;
            ctl_q     <= CTRL_IDLE;
            opc_q     <= '0;
            f3_q      <= '0;
            f7_q      <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every branch below sees the pre-edge register values.
            if (ctl_q.pcwrite) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            case (st_q)
                S_START: begin
                    st_q  <= S_FETCH;
                    ctl_q <= ctrl_for(S_FETCH, opc_q, f3_q, f7_q);
                end
                S_FETCH: begin
                    opc_q <= ins[6:0];
                    f3_q  <= ins[14:12];
                    f7_q  <= ins[30];
                    st_q  <= S_DECODE;
                    ctl_q <= ctrl_for(S_DECODE, ins[6:0], ins[14:12], ins[30]);
                end
                S_DECODE: begin
                    if (is_legal(opc_q)) begin
                        st_q  <= S_EXEC;
                        ctl_q <= ctrl_for(S_EXEC, opc_q, f3_q, f7_q);
                    end else if (HALT_ON_ILLEGAL) begin
                        st_q     <= S_HALT;
                        halted_q <= 1'b1;
                        ctl_q    <= CTRL_IDLE;
                    end else begin
                        st_q  <= S_FETCH;
                        ctl_q <= ctrl_for(S_FETCH, opc_q, f3_q, f7_q);
                    end
                end
                S_EXEC: begin
                    if (opc_q == OPC_BEQ || opc_q == OPC_JAL) begin
                        st_q  <= S_FETCH;
                        ctl_q <= ctrl_for(S_FETCH, opc_q, f3_q, f7_q);
                    end else if (opc_q == OPC_LOAD || opc_q == OPC_STORE) begin
                        st_q  <= S_MEM;
                        ctl_q <= ctrl_for(S_MEM, opc_q, f3_q, f7_q);
                    end else begin
                        st_q  <= S_WB;
                        ctl_q <= ctrl_for(S_WB, opc_q, f3_q, f7_q);
                    end
                end
                S_MEM: begin
                    if (opc_q == OPC_LOAD) begin
                        st_q  <= S_WB;
                        ctl_q <= ctrl_for(S_WB, opc_q, f3_q, f7_q);
                    end else begin
                        st_q  <= S_FETCH;
                        ctl_q <= ctrl_for(S_FETCH, opc_q, f3_q, f7_q);
                    end
                end
                S_WB: begin
                    st_q  <= S_FETCH;
                    ctl_q <= ctrl_for(S_FETCH, opc_q, f3_q, f7_q);
                end
                S_HALT: begin
                    st_q  <= S_HALT;
                    ctl_q <= CTRL_IDLE;
                end
                default: begin
                    st_q  <= S_START;
                    ctl_q <= CTRL_IDLE;
                end
            endcase
        end
    end

    assign IRWrite  = ctl_q.irwrite;
    assign RegWrite = ctl_q.regwrite;
    assign ALUSrc   = ctl_q.alusrc;
    assign op       = ctl_q.op;
    assign MemRead  = ctl_q.memread;
    assign MemWrite = ctl_q.memwrite;
    assign Mem2Reg  = ctl_q.mem2reg;
    assign Link     = ctl_q.link;
    assign PCWrite  = ctl_q.pcwrite;
    assign PCSel    = {ctl_q.pcsel[1], ctl_q.pcsel[0] | (ctl_q.br & zero)};
    assign state    = st_q;
    assign halted   = halted_q;
    assign retired  = retired_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control unit for the yIF/yID/yEX/yDM/yWB RV32 datapath. It produces every control strobe the datapath consumes: RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg and PC update. It does this from a latched instruction word, sequencing each instruction through per-class state paths. It also counts retired instructions and halts on an illegal opcode.

Parameters:
CNT_W, 32, width of retired-instruction counter
HALT_ON_ILLEGAL, 1, 1: illegal opcode enters HALT; 0: illegal opcode retires as a NOP

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
ins  input  32  instruction word from yIF, sampled in FETCH
zero  input  1  ALU zero flag from yEX, used in branch EXEC
IRWrite  output  1  instruction latch strobe (FETCH)
RegWrite  output  1  register-file write enable
ALUSrc  output  1  0: rd2, 1: imm
op  output  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
MemRead  output  1  data-memory read
MemWrite  output  1  data-memory write
Mem2Reg  output  1  0: ALU result, 1: memOut to write-back
Link  output  1  write-back selects PC+4 (jal)
PCWrite  output  1  PC update strobe
PCSel  output  2  0: PC+4, 1: branch target, 2: jTarget
state  output  3  current state (debug)
halted  output  1  sticky illegal-opcode flag
retired  output  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- States: START=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- On rst_n low: state=START, halted=0, retired=0, internal IR cleared. In START all outputs are 0 and op=010. START always goes to FETCH on the next edge.
- Outputs not listed for a state are 0; default op=010.
- FETCH: IRWrite=1. opcode, funct3 and funct7[5] are latched from ins at this edge. Next state is DECODE.
- DECODE: no strobes. Opcode 0x33/0x13/0x03/0x23/0x63/0x6F goes to EXEC. Any other opcode goes to HALT (halted<=1) if HALT_ON_ILLEGAL=1; otherwise goes to FETCH with PCWrite=1, PCSel=0 and counts as retired.
- EXEC, per latched opcode:
  - 0x33: ALUSrc=0.
  - 0x13/0x03/0x23: ALUSrc=1.
  - 0x63: ALUSrc=0, op=110, PCWrite=1, PCSel=zero?1:0 (Mealy on zero); next FETCH.
  - 0x6F: RegWrite=1, Link=1, PCWrite=1, PCSel=2; next FETCH.
  - Next state: 0x03/0x23 go to MEM; 0x33/0x13 go to WB.
- ALU op decode (0x33/0x13, held constant EXEC through WB):
  - funct3 000: add; sub only when R-type and funct7[5]=1.
  - 111: and. 110: or. 010: slt.
  - Other funct3: add.
  - Loads and stores use add.
- MEM:
  - 0x03: MemRead=1, next WB.
  - 0x23: MemWrite=1, ALUSrc=1, PCWrite=1, PCSel=0, next FETCH.
- WB:
  - RegWrite=1, PCWrite=1, PCSel=0, next FETCH.
  - Mem2Reg=1 for 0x03, else 0.
  - ALUSrc and op held from EXEC.
- Cycles per instruction, counted from FETCH: R/I 4, load 5, store 4, beq 3, jal 3.
- retired increments by 1 on every edge where PCWrite=1, and wraps to 0 at 2^CNT_W-1.
- HALT: all strobes 0, absorbing until rst_n low; halted=1 and retired frozen.
- Reset asserted mid-instruction aborts at once: no further strobes, state=START.
- ins changing outside FETCH has no effect.

Test Plan:
- Reset, then ins=0x002081B3 (add x3,x1,x2) → states 0,1,2,3,5,1. In WB: RegWrite=1, op=010, ALUSrc=0, PCWrite=1, PCSel=0. retired=1.
- ins=0x40208133 (sub) → op=110 in EXEC and WB. ins=0x0020F1B3 (and) → op=000.
- ins=0x00002283 (lw x5,0(x0)) → MEM: MemRead=1. WB: Mem2Reg=1, RegWrite=1. Takes 5 cycles. Then ins=0x00502223 (sw) → MEM: MemWrite=1, PCWrite=1, RegWrite never set.
- ins=0x00000463 (beq): with zero=1 in EXEC → PCSel=1. With zero=0 → PCSel=0. Both take 3 cycles and op=110.
- ins=0x008000EF (jal x1,8) → EXEC: RegWrite=1, Link=1, PCSel=2, PCWrite=1.
- ins=0x00000000 → HALT, halted=1, retired frozen, no strobes for 20 cycles. Pulse rst_n low mid-WB of a later add → state=0 and all strobes 0 at once, with no clock edge needed. With HALT_ON_ILLEGAL=0, the illegal opcode retires in 2 cycles.
